deb_evfifo: RTL and testbench

Parametrised successor to the fixed 11-input keypad debouncer. It debounces N_IN asynchronous switch/indicator inputs with a programmable hold time and converts each debounced press or release into an event word. Events are queued in a FIFO that the CPU reads through the asynchronous SRAM-style bus (ncs/noe/sram_data). Pops happen on read completion, and irq is raised by a FIFO fill threshold.

---
 rtl/deb_evfifo.sv | 147 ++++++++++++++
 tb/tb_deb_evfifo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/deb_evfifo.sv
// N-channel switch debouncer that turns each accepted press/release into an event word,
// queues the events in a small FIFO and serves them to the CPU over an async SRAM-style read bus.
module deb_evfifo #(
    parameter int N_IN       = 11,
    parameter int IDX_W      = 4,
    parameter int DATA_W     = 8,
    parameter int CNT_W      = 16,
    parameter int DEB_CYCLES = 50000,
    parameter int DEPTH_LOG2 = 3,
    parameter int IRQ_LEVEL  = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IN-1:0]   sw,
    input  logic              ncs,
    input  logic              noe,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              irq,
    output logic              led,
    output logic              ovf
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int EW    = IDX_W + 1;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [N_IN-1:0]       sw_act;
    logic [N_IN-1:0]       sw_s1_q, sw_s2_q;
    logic                  ncs_s1_q, ncs_s2_q, noe_s1_q, noe_s2_q, noe_s3_q;
    logic [N_IN-1:0]       stable_q, stable_d, pend_q, pend_d, flip, lowest, clr;
    logic [CNT_W-1:0]      cnt_q [N_IN];
    logic [CNT_W-1:0]      cnt_d [N_IN];
    logic [EW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_W-1:0]     word_q, word_d;
    logic                  irq_q, led_q, ovf_q, ovf_d;
    logic                  pop, push, push_any, push_lvl, full;
    logic [IDX_W-1:0]      push_idx;

    assign sw_act = (ACTIVE_LOW != 0) ? ~sw : sw;

    // A change is accepted on the DEB_CYCLES-th consecutive differing sample.
    always_comb begin
        flip     = '0;
        stable_d = stable_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
            if (sw_s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEB_CYCLES - 1)) begin
                    flip[i]     = 1'b1;
                    stable_d[i] = sw_s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Lowest-index pending channel wins the single push slot.
    always_comb begin
        push_any = 1'b0;
        push_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                push_any = 1'b1;
                push_idx = IDX_W'(i);
            end
        end
    end

    assign lowest   = pend_q & (~pend_q + N_IN'(1));
    assign push_lvl = |(stable_q & lowest);
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = noe_s2_q & ~noe_s3_q & ~ncs_s2_q & (count_q != '0);
    assign push     = push_any & (~full | pop);
    assign clr      = push ? lowest : '0;
    assign pend_d   = (pend_q & ~clr) | flip;
    assign ovf_d    = ovf_q | (|(flip & pend_q & ~clr));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        word_d = '0;
        if (count_q != '0) begin
            word_d[DATA_W-1] = 1'b1;
            word_d[EW-1:0]   = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            ncs_s1_q <= 1'b1;
            ncs_s2_q <= 1'b1;
            noe_s1_q <= 1'b1;
            noe_s2_q <= 1'b1;
            noe_s3_q <= 1'b1;
            stable_q <= '0;
            pend_q   <= '0;
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            word_q   <= '0;
            irq_q    <= 1'b0;
            led_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sw_s1_q  <= sw_act;
            sw_s2_q  <= sw_s1_q;
            ncs_s1_q <= ncs;
            ncs_s2_q <= ncs_s1_q;
            noe_s1_q <= noe;
            noe_s2_q <= noe_s1_q;
            noe_s3_q <= noe_s2_q;
            stable_q <= stable_d;
            pend_q   <= pend_d;
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            count_q  <= count_d;
            word_q   <= word_d;
            irq_q    <= (count_q >= CW'(IRQ_LEVEL));
            led_q    <= |stable_q;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {push_lvl, push_idx};
    end

    // Bus drive follows the raw strobes so the read data appears without clock latency.
    assign sram_data = (!ncs && !noe) ? word_q : {DATA_W{1'bz}};
    assign irq = irq_q;
    assign led = led_q;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_deb_evfifo.sv
// Bench for deb_evfifo: directed scenarios plus random switch/bus activity, all checked every
// cycle against an event-queue reference model.
module tb_deb_evfifo;
    localparam int N     = 11;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int IRQL  = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ncs = 1'b1;
    logic          noe = 1'b1;
    logic [N-1:0]  act = '0;
    logic [N-1:0]  sw;
    wire  [7:0]    sram_data;
    logic          irq, led, ovf;
    int            errors = 0;
    int            checks = 0;

    assign sw = ~act;

    deb_evfifo #(
        .N_IN(N), .IDX_W(4), .DATA_W(8), .CNT_W(8), .DEB_CYCLES(DEB),
        .DEPTH_LOG2(2), .IRQ_LEVEL(IRQL), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .sw(sw), .ncs(ncs), .noe(noe),
        .sram_data(sram_data), .irq(irq), .led(led), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference model: queue of ready-made bus words plus per-channel run lengths.
    logic [7:0] m_q[$];
    bit [N-1:0] m_s1, m_s2, m_stable, m_pend;
    int         m_run[N];
    bit         m_c1, m_c2, m_o1, m_o2, m_o3, m_ovf, m_irq, m_led;
    logic [7:0] m_word;

    function automatic void model_step();
        bit pop, psh, nirq, nled;
        int k;
        logic [7:0] entry, nword;
        bit [N-1:0] nstable, npend;
        if (reset) begin
            m_q.delete();
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_c1 = 1; m_c2 = 1; m_o1 = 1; m_o2 = 1; m_o3 = 1;
            m_ovf = 0; m_irq = 0; m_led = 0; m_word = 8'h00;
            return;
        end
        pop = m_o2 && !m_o3 && !m_c2 && (m_q.size() > 0);
        k = -1;
        for (int i = 0; i < N; i++) if (m_pend[i] && k < 0) k = i;
        psh = (k >= 0) && ((m_q.size() < DEPTH) || pop);
        entry = 8'h00;
        if (k >= 0) entry = {1'b1, 2'b00, m_stable[k], 4'(k)};
        nirq  = (m_q.size() >= IRQL);
        nled  = |m_stable;
        nword = (m_q.size() > 0) ? m_q[0] : 8'h00;
        nstable = m_stable;
        npend   = m_pend;
        if (psh) npend[k] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_s2[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_run[i]   = 0;
                    nstable[i] = m_s2[i];
                    if (npend[i]) m_ovf = 1;
                    npend[i] = 1'b1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (psh) m_q.push_back(entry);
        m_stable = nstable; m_pend = npend;
        m_irq = nirq; m_led = nled; m_word = nword;
        m_o3 = m_o2; m_o2 = m_o1; m_o1 = noe;
        m_c2 = m_c1; m_c1 = ncs;
        m_s2 = m_s1; m_s1 = act;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] ew;
        @(posedge clk);
        #1;
        model_step();
        chk("irq", 32'(irq), 32'(m_irq));
        chk("led", 32'(led), 32'(m_led));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        ew = '0;
        if (!ncs && !noe) ew[7:0] = m_word;
        else ew[7:0] = 8'bz;
        chk("bus", 32'(sram_data), ew);
    endtask

    task automatic bus_read(output logic [7:0] d);
        ncs = 1'b0; noe = 1'b0;
        repeat (4) tick();
        d = sram_data;
        noe = 1'b1;
        repeat (3) tick();
        ncs = 1'b1;
        tick();
    endtask

    task automatic read_expect(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(d);
        chk(tag, 32'(d), 32'(exp));
    endtask

    logic [7:0] full_press[6] = '{8'h91, 8'h92, 8'h93, 8'h94, 8'h96, 8'h98};
    logic [7:0] full_rel[6]   = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h86, 8'h88};

    initial begin
        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        read_expect("rst_word", 8'h00);

        // Glitch shorter than the hold time
        act[2] = 1'b1;
        repeat (3) tick();
        act[2] = 1'b0;
        repeat (10) tick();
        chk("glitch_irq", 32'(irq), 32'h0);
        chk("glitch_led", 32'(led), 32'h0);
        read_expect("glitch_empty", 8'h00);

        // Press then release of channel 5
        act[5] = 1'b1;
        repeat (20) tick();
        chk("press_led", 32'(led), 32'h1);
        act[5] = 1'b0;
        repeat (10) tick();
        chk("release_led", 32'(led), 32'h0);
        chk("two_irq", 32'(irq), 32'h1);
        read_expect("press5", 8'h95);
        read_expect("release5", 8'h85);
        chk("irq_drop", 32'(irq), 32'h0);

        // Simultaneous presses
        act[0] = 1'b1; act[7] = 1'b1;
        repeat (10) tick();
        read_expect("simul_first", 8'h90);
        read_expect("simul_second", 8'h97);
        act[0] = 1'b0; act[7] = 1'b0;
        repeat (10) tick();
        read_expect("simul_rel0", 8'h80);
        read_expect("simul_rel7", 8'h87);

        // Backpressure with six channels and a four-entry FIFO
        act = 11'h15E;
        repeat (12) tick();
        chk("full_irq", 32'(irq), 32'h1);
        for (int i = 0; i < 6; i++) read_expect("full_press", full_press[i]);
        read_expect("full_empty", 8'h00);
        chk("full_ovf", 32'(ovf), 32'h0);
        act = '0;
        repeat (12) tick();
        for (int i = 0; i < 6; i++) read_expect("full_rel", full_rel[i]);

        // Merge of a pending channel's press and release
        act = 11'h01E;
        repeat (10) tick();
        act[9] = 1'b1;
        repeat (10) tick();
        act[9] = 1'b0;
        repeat (10) tick();
        chk("merge_ovf", 32'(ovf), 32'h1);
        for (int i = 0; i < 4; i++) read_expect("merge_fill", full_press[i]);
        read_expect("merge_entry", 8'h89);
        read_expect("merge_empty", 8'h00);
        act = '0;
        repeat (10) tick();
        for (int i = 0; i < 4; i++) read_expect("merge_rel", full_rel[i]);

        // Reset in the middle of a read with entries queued
        act = 11'h00E;
        repeat (10) tick();
        ncs = 1'b0; noe = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("rstmid_irq", 32'(irq), 32'h0);
        chk("rstmid_ovf", 32'(ovf), 32'h0);
        chk("rstmid_word", 32'(sram_data), 32'h0);
        reset = 1'b0;
        repeat (DEB + 3) tick();
        chk("rstmid_pre", 32'(sram_data), 32'h0);
        tick();
        chk("rstmid_press", 32'(sram_data), 32'h91);
        noe = 1'b1;
        repeat (3) tick();
        ncs = 1'b1;
        tick();
        read_expect("rstmid_2", 8'h92);
        read_expect("rstmid_3", 8'h93);
        act = '0;
        repeat (10) tick();
        for (int i = 1; i < 4; i++) read_expect("rstmid_rel", full_rel[i - 1]);

        // Random switch, bus and reset activity against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                int c;
                c = int'($urandom_range(0, N - 1));
                act[c] = ~act[c];
            end
            if ($urandom_range(0, 15) == 0) ncs = ~ncs;
            if ($urandom_range(0, 3) == 0) noe = ~noe;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
